// File: rtl/icache_mshr_ctrl_pkg.sv
// icache_mshr_ctrl_pkg: bus commands, MSHR entry state and entry record shared by the miss controller
package icache_mshr_ctrl_pkg;
  localparam int LINE_BITS = 29;
  typedef enum logic [1:0] {BUS_NONE = 2'h0, BUS_LOAD = 2'h1, BUS_STORE = 2'h2} bus_command_e;
  typedef enum logic [1:0] {MSHR_FREE, MSHR_PENDING, MSHR_WAIT} mshr_state_e;
  typedef struct packed {
    mshr_state_e          state;
    logic [LINE_BITS-1:0] line;
    logic [3:0]           mem_tag;
  } mshr_entry_t;
endpackage

// File: rtl/icache_mshr_entry.sv
// icache_mshr_entry: one miss-status entry (state, line address, memory tag) with its tag-match compare
// ports: clock/reset; alloc+alloc_line load a new PENDING miss; issue+response move PENDING to WAIT;
// flush frees a PENDING entry; ret_tag is the returning bus tag; state/line/hit report the entry.
module icache_mshr_entry
  import icache_mshr_ctrl_pkg::*;
(
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 alloc,
  input  logic [LINE_BITS-1:0] alloc_line,
  input  logic                 issue,
  input  logic                 flush,
  input  logic [3:0]           response,
  input  logic [3:0]           ret_tag,
  output mshr_state_e          state,
  output logic [LINE_BITS-1:0] line,
  output logic                 hit
);
  mshr_entry_t entry_q, entry_d;
  assign state = entry_q.state;
  assign line  = entry_q.line;
  assign hit   = entry_q.state == MSHR_WAIT && entry_q.mem_tag == ret_tag && ret_tag != 4'd0;
  always_comb begin
    entry_d = entry_q;
    if (hit) begin
      entry_d.state   = MSHR_FREE;
      entry_d.mem_tag = 4'd0;
    end else if (alloc) begin
      entry_d.state = MSHR_PENDING;
      entry_d.line  = alloc_line;
    end else if (entry_q.state == MSHR_PENDING && flush) begin
      entry_d.state = MSHR_FREE;
    end else if (issue && response != 4'd0) begin
      entry_d.state   = MSHR_WAIT;
      entry_d.mem_tag = response;
    end
  end
  always_ff @(posedge clock) begin
    if (reset) entry_q <= '{state: MSHR_FREE, line: '0, mem_tag: 4'd0};
    else entry_q <= entry_d;
  end
endmodule

// File: rtl/icache_mshr_ctrl.sv
// icache_mshr_ctrl: multi-entry icache miss controller (dedup, allocate, issue one BUS_LOAD per cycle, fill by tag)
// ports: fetch lanes (proc2Icache_*), cache read side (cachemem_* in, Icache_*_out / rd_* out),
// memory bus (proc2Imem_* out, Imem2proc_* in), cache fill port (wr_*), flush, mshr_full.
module icache_mshr_ctrl
  import icache_mshr_ctrl_pkg::*;
#(
  parameter int FETCH_WIDTH = 4,
  parameter int NUM_MSHR    = 4,
  parameter int INDEX_BITS  = 5,
  parameter int TAG_BITS    = 8
) (
  input  logic                                   clock,
  input  logic                                   reset,
  input  logic [FETCH_WIDTH-1:0][31:0]           proc2Icache_addr,
  input  logic [FETCH_WIDTH-1:0]                 proc2Icache_en,
  input  logic [FETCH_WIDTH-1:0][63:0]           cachemem_data,
  input  logic [FETCH_WIDTH-1:0]                 cachemem_valid,
  input  logic                                   flush,
  input  logic [3:0]                             Imem2proc_response,
  input  logic [3:0]                             Imem2proc_tag,
  input  logic [63:0]                            Imem2proc_data,
  output logic [FETCH_WIDTH-1:0][63:0]           Icache_data_out,
  output logic [FETCH_WIDTH-1:0]                 Icache_valid_out,
  output logic [FETCH_WIDTH-1:0][INDEX_BITS-1:0] rd_idx,
  output logic [FETCH_WIDTH-1:0][TAG_BITS-1:0]   rd_tag,
  output logic [1:0]                             proc2Imem_command,
  output logic [31:0]                            proc2Imem_addr,
  output logic                                   wr_en,
  output logic [INDEX_BITS-1:0]                  wr_idx,
  output logic [TAG_BITS-1:0]                    wr_tag,
  output logic [63:0]                            wr_data,
  output logic                                   mshr_full
);
  mshr_state_e [NUM_MSHR-1:0]          ent_state;
  logic [NUM_MSHR-1:0][LINE_BITS-1:0]  ent_line, alloc_line;
  logic [NUM_MSHR-1:0]                 free, pend, hit, alloc, issue, avail;
  logic [FETCH_WIDTH-1:0]              miss, unused_addr;
  logic [FETCH_WIDTH-1:0][LINE_BITS-1:0] lane_line;
  logic [LINE_BITS-1:0]                wr_line, iss_line;
  logic                                dup, found, load;
  for (genvar g = 0; g < NUM_MSHR; g++) begin : g_ent
    icache_mshr_entry u_entry (
      .clock      (clock),
      .reset      (reset),
      .alloc      (alloc[g]),
      .alloc_line (alloc_line[g]),
      .issue      (issue[g]),
      .flush      (flush),
      .response   (Imem2proc_response),
      .ret_tag    (Imem2proc_tag),
      .state      (ent_state[g]),
      .line       (ent_line[g]),
      .hit        (hit[g])
    );
    assign free[g] = ent_state[g] == MSHR_FREE;
    assign pend[g] = ent_state[g] == MSHR_PENDING;
  end
  for (genvar l = 0; l < FETCH_WIDTH; l++) begin : g_lane
    assign miss[l]        = proc2Icache_en[l] & ~cachemem_valid[l];
    assign lane_line[l]   = proc2Icache_addr[l][31:3];
    assign rd_idx[l]      = proc2Icache_addr[l][3 +: INDEX_BITS];
    assign rd_tag[l]      = proc2Icache_addr[l][3+INDEX_BITS +: TAG_BITS];
    assign unused_addr[l] = ^proc2Icache_addr[l][2:0];
  end
  assign Icache_data_out  = cachemem_data;
  assign Icache_valid_out = cachemem_valid;
  assign mshr_full        = ~|free;
  // At most one WAIT entry can match a tag, so OR-ing the masked lines selects it.
  always_comb begin
    wr_line = '0;
    for (int e = 0; e < NUM_MSHR; e++) wr_line = wr_line | ({LINE_BITS{hit[e]}} & ent_line[e]);
  end
  assign wr_en   = |hit;
  assign wr_idx  = wr_line[0 +: INDEX_BITS];
  assign wr_tag  = wr_line[INDEX_BITS +: TAG_BITS];
  assign wr_data = Imem2proc_data;
  // Scanning downward leaves the lowest-numbered PENDING entry selected.
  always_comb begin
    issue    = '0;
    iss_line = '0;
    for (int e = NUM_MSHR - 1; e >= 0; e--) begin
      if (pend[e]) begin
        issue    = '0;
        issue[e] = ~flush;
        iss_line = ent_line[e];
      end
    end
  end
  assign load              = |pend && !flush;
  assign proc2Imem_command = load ? BUS_LOAD : BUS_NONE;
  assign proc2Imem_addr    = load ? {iss_line, 3'b000} : 32'd0;
  // Entries freed by this cycle's fill are not in free[], so they only become allocatable next cycle.
  always_comb begin
    alloc      = '0;
    alloc_line = '0;
    avail      = free;
    dup        = 1'b0;
    found      = 1'b0;
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      dup = wr_en && wr_line == lane_line[i];
      for (int e = 0; e < NUM_MSHR; e++) dup = dup | (!free[e] && ent_line[e] == lane_line[i]);
      for (int j = 0; j < i; j++) dup = dup | (miss[j] && lane_line[j] == lane_line[i]);
      found = 1'b0;
      if (miss[i] && !dup && !flush) begin
        for (int e = 0; e < NUM_MSHR; e++) begin
          if (avail[e] && !found) begin
            found         = 1'b1;
            avail[e]      = 1'b0;
            alloc[e]      = 1'b1;
            alloc_line[e] = lane_line[i];
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_icache_mshr_ctrl.sv
// tb_icache_mshr_ctrl: directed self-checking bench for the icache miss controller
module tb_icache_mshr_ctrl;
  localparam int FW = 4, NM = 4, IB = 5, TB = 8;
  logic                  clock = 1'b0, reset, flush;
  logic [FW-1:0][31:0]   addr;
  logic [FW-1:0]         en, valid;
  logic [FW-1:0][63:0]   cdata;
  logic [3:0]            response, mtag;
  logic [63:0]           mdata;
  logic [FW-1:0][63:0]   data_out;
  logic [FW-1:0]         valid_out;
  logic [FW-1:0][IB-1:0] rd_idx;
  logic [FW-1:0][TB-1:0] rd_tag;
  logic [1:0]            cmd;
  logic [31:0]           maddr;
  logic                  wr_en, full;
  logic [IB-1:0]         wr_idx;
  logic [TB-1:0]         wr_tag;
  logic [63:0]           wr_data;
  int errors = 0, checks = 0;
  icache_mshr_ctrl #(.FETCH_WIDTH(FW), .NUM_MSHR(NM), .INDEX_BITS(IB), .TAG_BITS(TB)) dut (
    .clock(clock), .reset(reset), .proc2Icache_addr(addr), .proc2Icache_en(en),
    .cachemem_data(cdata), .cachemem_valid(valid), .flush(flush),
    .Imem2proc_response(response), .Imem2proc_tag(mtag), .Imem2proc_data(mdata),
    .Icache_data_out(data_out), .Icache_valid_out(valid_out), .rd_idx(rd_idx), .rd_tag(rd_tag),
    .proc2Imem_command(cmd), .proc2Imem_addr(maddr), .wr_en(wr_en), .wr_idx(wr_idx),
    .wr_tag(wr_tag), .wr_data(wr_data), .mshr_full(full)
  );
  always #5 clock = ~clock;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clock);
    #1;
  endtask
  task automatic idle;
    en = '0; valid = '1; flush = 1'b0; response = 4'd0; mtag = 4'd0; mdata = 64'd0;
  endtask
  task automatic miss(input int lane, input logic [31:0] a);
    en[lane] = 1'b1; valid[lane] = 1'b0; addr[lane] = a;
  endtask
  task automatic bus(input string tag, input logic [1:0] c, input logic [31:0] a);
    check({tag, "_cmd"}, cmd, c);
    check({tag, "_addr"}, maddr, a);
  endtask
  task automatic fill(input string tag, input logic [3:0] t, input logic [IB-1:0] i, input logic [TB-1:0] g);
    mtag = t; mdata = {32'hF111_0000, 28'd0, t};
    #1;
    check({tag, "_wr_en"}, wr_en, 1'b1);
    check({tag, "_wr_idx"}, wr_idx, i);
    check({tag, "_wr_tag"}, wr_tag, g);
    check({tag, "_wr_data"}, wr_data, {32'hF111_0000, 28'd0, t});
  endtask
  initial begin
    reset = 1'b1; addr = '0; idle();
    for (int i = 0; i < FW; i++) cdata[i] = 64'hC0DE_0000_0000_0000 | 64'(i);
    tick(); tick();
    reset = 1'b0;
    #1;
    bus("reset", 2'd0, 32'd0);
    check("reset_wr_en", wr_en, 1'b0);
    check("reset_full", full, 1'b0);
    check("pass_data", data_out[2], 64'hC0DE_0000_0000_0002);
    check("pass_valid", valid_out, 4'hF);
    // single miss
    tick(); miss(0, 32'h100); #1;
    bus("t1_before", 2'd0, 32'd0);
    check("t1_rd_idx", rd_idx[0], 5'd0);
    check("t1_rd_tag", rd_tag[0], 8'd1);
    tick(); idle(); response = 4'd3; #1;
    bus("t1_issue", 2'd1, 32'h100);
    tick(); idle(); #1;
    bus("t1_wait", 2'd0, 32'd0);
    tick(); tick(); tick();
    fill("t1_fill", 4'd3, 5'd0, 8'd1);
    tick(); idle(); #1;
    check("t1_after_wr_en", wr_en, 1'b0);
    // duplicate misses across lanes
    for (int i = 0; i < FW; i++) miss(i, 32'h200);
    tick(); idle(); response = 4'd4; #1;
    bus("t2_issue", 2'd1, 32'h200);
    tick(); idle(); #1;
    bus("t2_single", 2'd0, 32'd0);
    check("t2_full", full, 1'b0);
    fill("t2_fill", 4'd4, 5'd0, 8'd2);
    tick(); idle();
    // four distinct misses
    for (int i = 0; i < FW; i++) miss(i, 32'(i * 'h40));
    tick(); idle(); response = 4'd5; #1;
    check("t3_full", full, 1'b1);
    bus("t3_iss0", 2'd1, 32'h000);
    tick(); idle(); response = 4'd6; #1; bus("t3_iss1", 2'd1, 32'h040);
    tick(); idle(); response = 4'd7; #1; bus("t3_iss2", 2'd1, 32'h080);
    tick(); idle(); response = 4'd8; #1; bus("t3_iss3", 2'd1, 32'h0C0);
    tick(); idle(); miss(0, 32'h600); #1;
    bus("t3_done", 2'd0, 32'd0);
    check("t3_full_wait", full, 1'b1);
    tick(); idle();
    fill("t3_fill8", 4'd8, 5'd24, 8'd0);
    bus("t3_overflow_dropped", 2'd0, 32'd0);
    check("t3_full_during_fill", full, 1'b1);
    tick(); idle(); miss(0, 32'h000);
    fill("t3_fill5", 4'd5, 5'd0, 8'd0);
    check("t3_full_freed", full, 1'b0);
    tick(); idle();
    fill("t3_fill7", 4'd7, 5'd16, 8'd0);
    bus("t3_fillmiss_dropped", 2'd0, 32'd0);
    tick(); idle();
    fill("t3_fill6", 4'd6, 5'd8, 8'd0);
    tick(); idle(); #1;
    check("t3_end_wr_en", wr_en, 1'b0);
    check("t3_end_full", full, 1'b0);
    // rejection and re-issue
    miss(0, 32'h300);
    for (int r = 0; r < 3; r++) begin
      tick(); idle(); #1;
      bus("t4_reject", 2'd1, 32'h300);
    end
    tick(); idle(); response = 4'd2; #1;
    bus("t4_accept", 2'd1, 32'h300);
    tick(); idle(); #1;
    bus("t4_wait", 2'd0, 32'd0);
    fill("t4_fill", 4'd2, 5'd0, 8'd3);
    tick(); idle();
    // flush with one WAIT and one PENDING entry
    miss(0, 32'h400);
    tick(); idle(); response = 4'd9; #1;
    bus("t5_issue", 2'd1, 32'h400);
    tick(); idle(); miss(0, 32'h480); #1;
    bus("t5_idle", 2'd0, 32'd0);
    tick(); idle(); flush = 1'b1; #1;
    bus("t5_flush", 2'd0, 32'd0);
    tick(); idle(); #1;
    bus("t5_after_flush", 2'd0, 32'd0);
    fill("t5_fill", 4'd9, 5'd0, 8'd4);
    tick(); idle(); #1;
    check("t5_full", full, 1'b0);
    // reset with two WAIT entries
    miss(0, 32'h500); miss(1, 32'h540);
    tick(); idle(); response = 4'd10; #1; bus("t6_iss0", 2'd1, 32'h500);
    tick(); idle(); response = 4'd11; #1; bus("t6_iss1", 2'd1, 32'h540);
    tick(); idle(); reset = 1'b1;
    tick(); reset = 1'b0; mtag = 4'd10; #1;
    check("t6_late10_wr_en", wr_en, 1'b0);
    bus("t6_reset", 2'd0, 32'd0);
    check("t6_full", full, 1'b0);
    tick(); mtag = 4'd11; #1;
    check("t6_late11_wr_en", wr_en, 1'b0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/icache_mshr_ctrl.md
# icache_mshr_ctrl

Parametrised instruction-cache miss controller that sits between the fetch stage, the icache data/tag memory and the shared memory bus. It generalises the single-miss icache controller: a table of NUM_MSHR miss-status entries tracks several outstanding line fills at once. It merges duplicate misses across FETCH_WIDTH lanes and issues at most one BUS_LOAD per cycle. Each memory response is matched to its entry by memory tag and written into the cache.

## Interface
Parameters:
- FETCH_WIDTH, 4, number of fetch lanes
- NUM_MSHR, 4, outstanding-miss entries (≥1, ≤15 usable memory tags)
- INDEX_BITS, 5, cache set index width, taken from addr[3 +: INDEX_BITS]
- TAG_BITS, 8, cache tag width, taken from addr[3+INDEX_BITS +: TAG_BITS]

Ports:
- clock  in  1  single clock; all state updates on posedge
- reset  in  1  synchronous, active-high
- proc2Icache_addr  in  FETCH_WIDTH×32  fetch addresses
- proc2Icache_en  in  FETCH_WIDTH  lane requests
- cachemem_data  in  FETCH_WIDTH×64  cache read data
- cachemem_valid  in  FETCH_WIDTH  cache hit per lane
- flush  in  1  drop all un-issued misses (redirect)
- Imem2proc_response  in  4  bus-accepted tag; 0 = rejected
- Imem2proc_tag  in  4  tag of the returning line; 0 = none
- Imem2proc_data  in  64  returning line
- Icache_data_out / Icache_valid_out  out  FETCH_WIDTH×64 / FETCH_WIDTH  pass-through of cachemem_data / cachemem_valid
- rd_idx / rd_tag  out  FETCH_WIDTH×INDEX_BITS / FETCH_WIDTH×TAG_BITS  per-lane cache lookup fields
- proc2Imem_command  out  2  BUS_NONE or BUS_LOAD
- proc2Imem_addr  out  32  {line, 3'b0}
- wr_en, wr_idx, wr_tag, wr_data  out  1, INDEX_BITS, TAG_BITS, 64  cache fill write port
- mshr_full  out  1  no FREE entry

## Operation
- Entry fields: state (FREE / PENDING / WAIT), line address addr[31:3], mem_tag[3:0].
- **Miss:** a lane misses when en=1 and valid=0.
- **Dedup:** a miss is dropped when its line equals:
  - any non-FREE entry, or
  - a lower-numbered miss lane in the same cycle, or
  - the line being filled this cycle (wr_en=1).
- **Allocation:** each remaining distinct miss takes the lowest-numbered FREE entry, in lane order (lane 0 first), and becomes PENDING.
  - Misses beyond the free entries are ignored. Fetch re-presents them next cycle.
- **Issue:** when a PENDING entry exists and this cycle is not a flush, drive BUS_LOAD with the lowest-numbered PENDING entry's address.
  - Imem2proc_response ≠ 0: entry → WAIT and mem_tag ← response.
  - Imem2proc_response = 0: entry stays PENDING and is re-issued next cycle.
- **Fill:** a WAIT entry with mem_tag == Imem2proc_tag (tag ≠ 0) drives the write port for one cycle.
  - wr_en=1, wr_idx/wr_tag are taken from the stored line, wr_data = Imem2proc_data.
  - The entry → FREE.
- **Flush:** all PENDING entries → FREE and no request is issued that cycle. WAIT entries still complete their fill.
- Tag 0 never matches, and no more than one entry matches a given tag.

## Timing
- **Reset values:** all entries FREE, mem_tags 0. proc2Imem_command=BUS_NONE, proc2Imem_addr=0, wr_en=0, mshr_full=0.
- **Miss to request:** a miss seen in cycle N is allocated at the N+1 edge, and the earliest BUS_LOAD is in cycle N+1.
- **Request outputs:** command/addr are combinational from the registered entry state. Response is sampled in the same cycle.
- **Fill:** wr_* are combinational from Imem2proc_tag in the cycle the tag returns. The freed entry becomes allocatable in the next cycle.
- **Simultaneous fill + allocate:** allowed on different entries. A miss on the line being filled is dropped.
- **Reset or flush during an outstanding miss:**
  - After reset, late tags match nothing and produce no write.
  - After flush, responses to in-flight (WAIT) requests are still written.
- **Full:** mshr_full=1 whenever no entry is FREE. Issue and fill proceed normally while full.

## Structure
- The shared package holds:
  - BUS_NONE / BUS_LOAD (existing sys_defs)
  - typedef enum mshr_state_e {MSHR_FREE, MSHR_PENDING, MSHR_WAIT}
  - typedef struct mshr_entry_t
- Sub-module **icache_mshr_entry**: one entry's state register, line, mem_tag and tag-match compare, instantiated NUM_MSHR times.
- The top level holds dedup, lowest-free/lowest-pending priority encoders and output muxing.

## Test plan
- **Single miss:** lane0 misses addr 0x100, response=3, tag 3 returns 4 cycles later → one BUS_LOAD addr 0x100, then wr_en with wr_idx=0, wr_tag=1, entry FREE.
- **Duplicate misses:** lanes 0..3 all miss 0x200 → exactly one entry and one request.
- **Four distinct misses:** 0x000/0x040/0x080/0x0C0 in one cycle → four entries, mshr_full=1, requests in lane order. Responses 5,6,7,8 returned in order 8,5,7,6 → each fill goes to the correct index.
- **Rejection:** response=0 for 3 cycles, then 2 → same address re-issued 4 times, then entry → WAIT.
- **Flush:** flush while one entry is PENDING and one is WAIT → PENDING freed and never issued; the WAIT entry's tag still writes.
- **Reset:** reset with two entries in WAIT, then their tags return → no wr_en, all outputs at reset values.
